axi_lite_master: RTL and testbench



---
 rtl/axi_lite_master_if.sv | 31 +++
 rtl/axi_lite_master.sv | 167 ++++++++++++++++
 tb/tb_axi_lite_master.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_master_if.sv
// AXI-lite channel bundle between axi_lite_master and its memory-side slave.
// Carries only the AR/R/AW/W/B handshakes with address/data; no RESP or STRB fields.
interface axi_lite_master_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0] ARADDR;
  logic              ARVALID;
  logic              ARREADY;
  logic [DATA_W-1:0] RDATA;
  logic              RVALID;
  logic              RREADY;
  logic [ADDR_W-1:0] AWADDR;
  logic              AWVALID;
  logic              AWREADY;
  logic [DATA_W-1:0] WDATA;
  logic              WVALID;
  logic              WREADY;
  logic              BVALID;
  logic              BREADY;

  modport master (
    output ARADDR, ARVALID, RREADY, AWADDR, AWVALID, WDATA, WVALID, BREADY,
    input  ARREADY, RDATA, RVALID, AWREADY, WREADY, BVALID
  );

  modport slave (
    input  ARADDR, ARVALID, RREADY, AWADDR, AWVALID, WDATA, WVALID, BREADY,
    output ARREADY, RDATA, RVALID, AWREADY, WREADY, BVALID
  );
endinterface

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI-lite master: turns one CPU load/store request at a time into
// AR/R or AW/W/B handshakes and returns a one-cycle response pulse with read data.
module axi_lite_master #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              ACLK,
  input  logic              ARESETN,    // active-high despite the name
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  axi_lite_master_if.master bus
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StRdAddr = 3'd1;
  localparam logic [2:0] StRdData = 3'd2;
  localparam logic [2:0] StWrReq  = 3'd3;
  localparam logic [2:0] StWrResp = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              bready_q, bready_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              aw_hs, w_hs;

  assign aw_hs = awvalid_q & bus.AWREADY;
  assign w_hs  = wvalid_q & bus.WREADY;

  // Next-state and registered-output decode for the transaction FSM.
  always_comb begin
    state_d      = state_q;
    araddr_d     = araddr_q;
    awaddr_d     = awaddr_q;
    wdata_d      = wdata_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;

    case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (req_we) begin
            awaddr_d  = req_addr;
            wdata_d   = req_wdata;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = StWrReq;
          end else begin
            araddr_d  = req_addr;
            arvalid_d = 1'b1;
            state_d   = StRdAddr;
          end
        end
      end
      StRdAddr: begin
        if (arvalid_q && bus.ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = StRdData;
        end
      end
      StRdData: begin
        if (bus.RVALID) begin
          rready_d     = 1'b0;
          resp_rdata_d = bus.RDATA;
          resp_valid_d = 1'b1;
          state_d      = StIdle;
        end
      end
      StWrReq: begin
        // AW and W complete independently; either may finish first or both together.
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          bready_d  = 1'b1;
          state_d   = StWrResp;
        end
      end
      StWrResp: begin
        if (bus.BVALID) begin
          bready_d     = 1'b0;
          resp_valid_d = 1'b1;
          state_d      = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight transaction.
  always_ff @(posedge ACLK or posedge ARESETN) begin
    if (ARESETN) begin
      state_q      <= StIdle;
      araddr_q     <= '0;
      awaddr_q     <= '0;
      wdata_q      <= '0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      araddr_q     <= araddr_d;
      awaddr_q     <= awaddr_d;
      wdata_q      <= wdata_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign req_ready   = (state_q == StIdle);
  assign resp_valid  = resp_valid_q;
  assign resp_rdata  = resp_rdata_q;
  assign bus.ARADDR  = araddr_q;
  assign bus.ARVALID = arvalid_q;
  assign bus.RREADY  = rready_q;
  assign bus.AWADDR  = awaddr_q;
  assign bus.AWVALID = awvalid_q;
  assign bus.WDATA   = wdata_q;
  assign bus.WVALID  = wvalid_q;
  assign bus.BREADY  = bready_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: delay-programmable slave model, protocol monitor,
// table of transactions checked through a response scoreboard, plus corner sequences.
module tb_axi_lite_master;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          ACLK = 1'b0;
  logic          ARESETN = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          resp_valid;
  logic [DW-1:0] resp_rdata;

  axi_lite_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  axi_lite_master #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .ACLK       (ACLK),
    .ARESETN    (ARESETN),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .bus        (bus)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;      // data the slave returns on R
    int          ar_dly;
    int          r_dly;
    int          aw_dly;
    int          w_dly;
    int          b_dly;
    logic [31:0] exp_rdata;  // resp_rdata expected at resp_valid
    int          lat;        // cycles from acceptance edge to resp_valid cycle
  } vec_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          acc;
    int          lat;
  } sb_t;

  sb_t sb_q[$];
  int  n_checks = 0;
  int  n_pass = 0;
  int  resp_cnt = 0;
  int  exp_resp = 0;
  int  cyc = 0;

  // Slave configuration and observations
  int          cfg_ar_dly = 0, cfg_r_dly = 0, cfg_aw_dly = 0, cfg_w_dly = 0, cfg_b_dly = 0;
  logic [31:0] cfg_rdata = '0;
  bit          stray_r = 1'b0, stray_b = 1'b0;
  logic [31:0] obs_araddr = '0, obs_awaddr = '0, obs_wdata = '0;
  int          stab_err = 0, proto_err = 0;

  initial begin
    forever begin
      @(posedge ACLK);
      cyc++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
  endtask

  // Slave model plus protocol monitor, all evaluated on the falling edge.
  initial begin
    int   ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    bit   ar_seen, aw_seen, w_seen;
    logic [31:0] ar_first, aw_first, w_first;
    bit   p_arv, p_arr, p_awv, p_awr, p_wv, p_wr;
    ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    ar_seen = 0; aw_seen = 0; w_seen = 0;
    ar_first = '0; aw_first = '0; w_first = '0;
    p_arv = 0; p_arr = 0; p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0;
    bus.ARREADY = 1'b0; bus.RVALID = 1'b0; bus.RDATA = '0;
    bus.AWREADY = 1'b0; bus.WREADY = 1'b0; bus.BVALID = 1'b0;
    forever begin
      @(negedge ACLK);
      if (ARESETN) begin
        p_arv = 0; p_arr = 0; p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0;
      end else begin
        if (bus.BREADY && (bus.AWVALID || bus.WVALID || bus.ARVALID || bus.RREADY)) proto_err++;
        if (bus.RREADY && (bus.ARVALID || bus.AWVALID || bus.WVALID)) proto_err++;
        if (bus.ARVALID && (bus.AWVALID || bus.WVALID)) proto_err++;
        // Valid withdrawn without handshake, or left high after handshake
        if (p_arv && !p_arr && !bus.ARVALID) proto_err++;
        if (p_arv && p_arr && bus.ARVALID) proto_err++;
        if (p_awv && !p_awr && !bus.AWVALID) proto_err++;
        if (p_awv && p_awr && bus.AWVALID) proto_err++;
        if (p_wv && !p_wr && !bus.WVALID) proto_err++;
        if (p_wv && p_wr && bus.WVALID) proto_err++;
      end

      if (bus.ARVALID) begin
        if (!ar_seen) begin ar_first = bus.ARADDR; ar_seen = 1'b1; end
        else if (bus.ARADDR !== ar_first) stab_err++;
        if (!bus.ARREADY) begin
          if (ar_cnt >= cfg_ar_dly) begin bus.ARREADY = 1'b1; obs_araddr = bus.ARADDR; end
          else ar_cnt++;
        end
      end else begin
        bus.ARREADY = 1'b0; ar_cnt = 0; ar_seen = 1'b0;
      end

      if (stray_r) begin
        bus.RVALID = 1'b1; bus.RDATA = 32'hBAD0_BAD0;
      end else if (!bus.RREADY) begin
        bus.RVALID = 1'b0; r_cnt = 0;
      end else if (!bus.RVALID) begin
        if (r_cnt >= cfg_r_dly) begin bus.RVALID = 1'b1; bus.RDATA = cfg_rdata; end
        else r_cnt++;
      end

      if (bus.AWVALID) begin
        if (!aw_seen) begin aw_first = bus.AWADDR; aw_seen = 1'b1; end
        else if (bus.AWADDR !== aw_first) stab_err++;
        if (!bus.AWREADY) begin
          if (aw_cnt >= cfg_aw_dly) begin bus.AWREADY = 1'b1; obs_awaddr = bus.AWADDR; end
          else aw_cnt++;
        end
      end else begin
        bus.AWREADY = 1'b0; aw_cnt = 0; aw_seen = 1'b0;
      end

      if (bus.WVALID) begin
        if (!w_seen) begin w_first = bus.WDATA; w_seen = 1'b1; end
        else if (bus.WDATA !== w_first) stab_err++;
        if (!bus.WREADY) begin
          if (w_cnt >= cfg_w_dly) begin bus.WREADY = 1'b1; obs_wdata = bus.WDATA; end
          else w_cnt++;
        end
      end else begin
        bus.WREADY = 1'b0; w_cnt = 0; w_seen = 1'b0;
      end

      if (stray_b) begin
        bus.BVALID = 1'b1;
      end else if (!bus.BREADY) begin
        bus.BVALID = 1'b0; b_cnt = 0;
      end else if (!bus.BVALID) begin
        if (b_cnt >= cfg_b_dly) bus.BVALID = 1'b1;
        else b_cnt++;
      end

      p_arv = bus.ARVALID; p_arr = bus.ARREADY;
      p_awv = bus.AWVALID; p_awr = bus.AWREADY;
      p_wv  = bus.WVALID;  p_wr  = bus.WREADY;
    end
  end

  // Advance to the next falling edge and retire any response against the scoreboard.
  task automatic step();
    sb_t e;
    @(negedge ACLK);
    if (!ARESETN && resp_valid) begin
      resp_cnt++;
      if (sb_q.size() == 0) begin
        check("unexpected_resp", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("resp_rdata", resp_rdata, e.exp_rdata);
        check("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
        if (e.we) begin
          check("awaddr", obs_awaddr, e.addr);
          check("wdata", obs_wdata, e.wdata);
        end else begin
          check("araddr", obs_araddr, e.addr);
        end
      end
    end
  endtask

  task automatic issue(input vec_t v, input bit hold, output bit resp_seen);
    int  k;
    sb_t e;
    if (v.we) begin
      cfg_aw_dly = v.aw_dly; cfg_w_dly = v.w_dly; cfg_b_dly = v.b_dly;
    end else begin
      cfg_ar_dly = v.ar_dly; cfg_r_dly = v.r_dly; cfg_rdata = v.rdata;
    end
    req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata;
    k = 0;
    while (!req_ready && k < 200) begin step(); k++; end
    resp_seen = resp_valid;
    if (!req_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge ACLK);
    step();
    e.we = v.we; e.addr = v.addr; e.wdata = v.wdata;
    e.exp_rdata = v.exp_rdata; e.acc = cyc; e.lat = v.lat;
    sb_q.push_back(e);
    exp_resp++;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (sb_q.size() != 0 && k < 200) begin step(); k++; end
    if (sb_q.size() != 0) begin
      check("resp_timeout", 32'(sb_q.size()), 32'd0);
      exp_resp -= sb_q.size();
      sb_q.delete();
    end
    step();
  endtask

  task automatic check_reset(input string p);
    check({p, "_req_ready"},  32'(req_ready), 32'd1);
    check({p, "_arvalid"},    32'(bus.ARVALID), 32'd0);
    check({p, "_awvalid"},    32'(bus.AWVALID), 32'd0);
    check({p, "_wvalid"},     32'(bus.WVALID), 32'd0);
    check({p, "_rready"},     32'(bus.RREADY), 32'd0);
    check({p, "_bready"},     32'(bus.BREADY), 32'd0);
    check({p, "_resp_valid"}, 32'(resp_valid), 32'd0);
    check({p, "_araddr"},     bus.ARADDR, 32'd0);
    check({p, "_awaddr"},     bus.AWADDR, 32'd0);
    check({p, "_wdata"},      bus.WDATA, 32'd0);
    check({p, "_resp_rdata"}, resp_rdata, 32'd0);
  endtask

  initial begin
    vec_t vecs[8];
    vec_t v;
    bit   seen;
    int   k;
    //        we    addr           wdata          rdata         ar r aw w b exp_rdata     lat
    vecs[0] = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1, 2, 0, 0, 0, 32'hDEAD_BEEF, 6};
    vecs[1] = '{1'b1, 32'h0000_0020, 32'h1234_5678, 32'h0,         0, 0, 0, 3, 0, 32'hDEAD_BEEF, 6};
    vecs[2] = '{1'b1, 32'h0000_0024, 32'hCAFE_F00D, 32'h0,         0, 0, 0, 0, 0, 32'hDEAD_BEEF, 3};
    vecs[3] = '{1'b0, 32'h0000_0030, 32'h0,         32'hA5A5_5A5A, 0, 0, 0, 0, 0, 32'hA5A5_5A5A, 3};
    vecs[4] = '{1'b1, 32'h0000_0034, 32'h0000_0001, 32'h0,         0, 0, 3, 0, 2, 32'hA5A5_5A5A, 8};
    vecs[5] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         32'h0000_0000, 2, 0, 0, 0, 0, 32'h0000_0000, 5};
    vecs[6] = '{1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'h0,         0, 0, 1, 1, 1, 32'h0000_0000, 5};
    vecs[7] = '{1'b0, 32'h0000_0000, 32'h0,         32'hFFFF_FFFF, 0, 1, 0, 0, 0, 32'hFFFF_FFFF, 4};

    repeat (3) @(posedge ACLK);
    step();
    check_reset("reset");
    ARESETN = 1'b0;
    step();

    for (int i = 0; i < 8; i++) begin
      issue(vecs[i], 1'b0, seen);
      wait_done();
      check("idle_req_ready", 32'(req_ready), 32'd1);
    end

    // Back-to-back read then write with req_valid held high
    v = '{1'b0, 32'h0000_0040, 32'h0, 32'h0BAD_CAFE, 0, 0, 0, 0, 0, 32'h0BAD_CAFE, 3};
    issue(v, 1'b1, seen);
    v = '{1'b1, 32'h0000_0044, 32'h55AA_33CC, 32'h0, 0, 0, 0, 0, 0, 32'h0BAD_CAFE, 3};
    issue(v, 1'b0, seen);
    check("b2b_accept_in_resp_cycle", 32'(seen), 32'd1);
    wait_done();

    // Reset while waiting in RD_DATA
    v = '{1'b0, 32'h0000_0050, 32'h0, 32'h1111_2222, 0, 1000, 0, 0, 0, 32'h1111_2222, 3};
    issue(v, 1'b0, seen);
    k = 0;
    while (!bus.RREADY && k < 20) begin step(); k++; end
    check("mid_rst_in_rd_data", 32'(bus.RREADY), 32'd1);
    ARESETN = 1'b1;
    #1;
    check_reset("mid_rst");
    sb_q.delete();
    exp_resp--;
    step();
    step();
    ARESETN = 1'b0;
    stray_r = 1'b1;
    repeat (3) step();
    stray_r = 1'b0;
    step();
    check("stray_r_resp_count", 32'(resp_cnt), 32'(exp_resp));
    check("stray_r_resp_rdata", resp_rdata, 32'd0);
    check("stray_r_req_ready", 32'(req_ready), 32'd1);
    v = '{1'b0, 32'h0000_0054, 32'h0, 32'h7777_8888, 0, 0, 0, 0, 0, 32'h7777_8888, 3};
    issue(v, 1'b0, seen);
    wait_done();

    // BVALID while idle
    stray_b = 1'b1;
    repeat (3) step();
    check("stray_b_idle_bready", 32'(bus.BREADY), 32'd0);
    stray_b = 1'b0;
    step();
    check("stray_b_idle_resp_count", 32'(resp_cnt), 32'(exp_resp));
    check("stray_b_idle_req_ready", 32'(req_ready), 32'd1);

    // BVALID while in RD_DATA must not complete the read
    v = '{1'b0, 32'h0000_0060, 32'h0, 32'h1357_9BDF, 0, 4, 0, 0, 0, 32'h1357_9BDF, 7};
    issue(v, 1'b0, seen);
    k = 0;
    while (!bus.RREADY && k < 20) begin step(); k++; end
    stray_b = 1'b1;
    step();
    step();
    stray_b = 1'b0;
    wait_done();

    check("resp_count", 32'(resp_cnt), 32'(exp_resp));
    check("protocol_errors", 32'(proto_err), 32'd0);
    check("stability_errors", 32'(stab_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
